register_file: RTL and testbench

//  32-entry x 64-bit LEGv8-style integer register file for the single-cycle datapath.
//  Two asynchronous (combinational) read ports, BusA and BusB, and one synchronous write port.

---
 rtl/register_file.sv | 35 +++
 tb/tb_register_file.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32x64 register file, two combinational read ports, falling-edge write, XZR hardwired to zero
module register_file #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] RW,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    logic [DATA_W-1:0] r_mem [N];
    logic              w_we;
    assign w_we = RegWr && (RW != ZR);
    // Falling-edge write so results land mid-cycle; reset clears every entry at once
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[RW] <= BusW;
        end
    end
    // Combinational reads with no write bypass; XZR always reads zero
    always_comb begin
        BusA = (RA == ZR) ? '0 : r_mem[RA];
        BusB = (RB == ZR) ? '0 : r_mem[RB];
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed check of register_file against an array model
module tb_register_file;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [63:0] BusW = '0;
    logic [4:0]  RW = '0;
    logic        RegWr = 1'b0;
    logic [4:0]  RA = '0;
    logic [4:0]  RB = '0;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [63:0] m [32];
    int checks = 0;
    int errors = 0;

    register_file dut (
        .Clk(Clk), .Reset(Reset), .BusW(BusW), .RW(RW), .RegWr(RegWr),
        .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rd(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : m[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = '0;
    endtask

    task automatic wr(input string tag, input logic [4:0] rw, input logic [63:0] w,
                      input logic we, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge Clk);
        #1;
        RW = rw; BusW = w; RegWr = we; RA = ra; RB = rb;
        #1;
        chk({tag, "_preA"}, BusA, rd(ra));
        chk({tag, "_preB"}, BusB, rd(rb));
        @(negedge Clk);
        if (!Reset && we && rw != 5'd31) m[rw] = w;
        #1;
        chk({tag, "_postA"}, BusA, rd(ra));
        chk({tag, "_postB"}, BusB, rd(rb));
        RegWr = 1'b0;
    endtask

    initial begin
        clear_model();
        #2 Reset = 1'b1;
        #1;
        for (int a = 0; a < 32; a += 7) begin
            RA = 5'(a); RB = 5'(31 - a);
            #1;
            chk("rst_A", BusA, 64'd0);
            chk("rst_B", BusB, 64'd0);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;

        wr("zero", 5'd31, 64'h12345678, 1'b1, 5'd31, 5'd31);
        chk("zero_A", BusA, 64'd0);
        chk("zero_B", BusB, 64'd0);

        for (int i = 0; i < 31; i++)
            wr("fill", 5'(i), 64'(i), 1'b1, 5'(i), 5'(i + 1));
        chk("fill30_B31", BusB, 64'd0);
        chk("fill30_A", BusA, 64'd30);

        @(posedge Clk);
        #1 RW = 5'd1; BusW = 64'h12345678; RegWr = 1'b1; RA = 5'd1; RB = 5'd2;
        #1;
        chk("we_preA", BusA, 64'd1);
        chk("we_preB", BusB, 64'd2);
        @(negedge Clk);
        m[1] = 64'h12345678;
        #1;
        chk("we_postA", BusA, 64'h12345678);
        chk("we_postB", BusB, 64'd2);
        RegWr = 1'b0;

        wr("wdis", 5'd3, 64'h12345678, 1'b0, 5'd3, 5'd4);
        chk("wdis_A", BusA, 64'd3);
        chk("wdis_B", BusB, 64'd4);

        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            RA = 5'(5 + i); RB = 5'(20 - i);
            #1;
            chk("rtime_A", BusA, 64'(5 + i));
            chk("rtime_B", BusB, 64'(20 - i));
        end

        @(posedge Clk);
        #2 Reset = 1'b1;
        clear_model();
        #1;
        for (int a = 0; a < 32; a++) begin
            RA = 5'(a); RB = 5'(31 - a);
            #0.1;
            chk("arst_A", BusA, 64'd0);
            chk("arst_B", BusB, 64'd0);
        end
        wr("rst_wr", 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b1, 5'd5, 5'd6);
        chk("rst_wr_A", BusA, 64'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;

        for (int n = 0; n < 300; n++) begin
            logic [4:0] rw;
            rw = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0)
                wr("rnd", rw, {$urandom, $urandom}, 1'($urandom), rw, 5'($urandom_range(0, 31)));
            else
                wr("rnd", rw, {$urandom, $urandom}, 1'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        for (int a = 0; a < 32; a++) begin
            RA = 5'(a); RB = 5'(a);
            #1;
            chk("final_A", BusA, rd(5'(a)));
            chk("final_B", BusB, rd(5'(a)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
